// File: rtl/ram_rd_streamer.sv
//==============================================================================
//  Module   : ram_rd_streamer
//  Purpose  : Read engine for ram_1r1w_sync_backpressure. Accepts a command
//             (base address, element count), issues sequential reads to the
//             RAM with address wrap at ELS_P-1, and returns the responses as a
//             valid/ready beat stream with a last flag.
//  Ports    : clk, rst_n                  clock, async active-low reset
//             cmd_val/cmd_rdy             command handshake
//             cmd_base_addr, cmd_num_els  first entry, entry count (0 legal)
//             rd_req_val/rdy/addr         RAM read-request port
//             rd_resp_val/rdy/data        RAM read-response port
//             out_val/rdy/data/last       output beat stream
//             busy                        command in progress
//  Options  : RAM_RD_STREAMER_OUT_REG_EN  registers the output through a
//             2-entry skid buffer (first beat one cycle later, full rate).
//  Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_rd_streamer #(
    parameter int WIDTH_P  = 256,
    parameter int ELS_P    = 64,
    parameter int ADDR_W_P = (ELS_P > 1) ? $clog2(ELS_P) : 1,
    parameter int LEN_W_P  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_val,
    input  logic [ADDR_W_P-1:0] cmd_base_addr,
    input  logic [LEN_W_P-1:0]  cmd_num_els,
    output logic                cmd_rdy,
    output logic                rd_req_val,
    output logic [ADDR_W_P-1:0] rd_req_addr,
    input  logic                rd_req_rdy,
    input  logic                rd_resp_val,
    input  logic [WIDTH_P-1:0]  rd_resp_data,
    output logic                rd_resp_rdy,
    output logic                out_val,
    output logic [WIDTH_P-1:0]  out_data,
    output logic                out_last,
    input  logic                out_rdy,
    output logic                busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic [ADDR_W_P-1:0] c_last_addr = ADDR_W_P'(ELS_P - 1);

    logic [1:0]          r_state;
    logic [ADDR_W_P-1:0] r_cur_addr;
    logic [LEN_W_P-1:0]  r_num_els;
    logic [LEN_W_P-1:0]  r_issued_cnt;
    logic [LEN_W_P-1:0]  r_recv_cnt;

    logic                w_busy;
    logic                w_cmd_hs;
    logic                w_req_hs;
    logic                w_out_hs;
    logic                w_recv_last;
    logic                w_recv_inc;
    logic [LEN_W_P-1:0]  w_issued_nxt;

    assign w_busy       = (r_state != c_st_idle);
    assign cmd_rdy      = (r_state == c_st_idle);
    assign busy         = w_busy;
    assign rd_req_val   = (r_state == c_st_issue);
    assign rd_req_addr  = r_cur_addr;

    assign w_cmd_hs     = cmd_val & cmd_rdy;
    assign w_req_hs     = rd_req_val & rd_req_rdy;
    assign w_out_hs     = out_val & out_rdy;
    assign w_issued_nxt = r_issued_cnt + LEN_W_P'(1);
    // Response currently being received is the final one of the command.
    assign w_recv_last  = (r_recv_cnt == (r_num_els - LEN_W_P'(1)));

`ifdef RAM_RD_STREAMER_OUT_REG_EN
    // Two entries let a response be accepted on the same cycle the head
    // leaves, so rd_resp_rdy never drops while out_rdy is high.
    logic [WIDTH_P:0] r_skid [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full      = (r_count == 2'd2);
    assign w_push      = w_busy & rd_resp_val & ~w_full;
    assign w_pop       = (r_count != 2'd0) & out_rdy;
    assign rd_resp_rdy = w_busy & ~w_full;
    assign out_val     = (r_count != 2'd0);
    assign out_data    = r_skid[r_rd_ptr][WIDTH_P-1:0];
    assign out_last    = out_val & r_skid[r_rd_ptr][WIDTH_P];
    assign w_recv_inc  = w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid[0] <= '0;
            r_skid[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_skid[r_wr_ptr] <= {w_recv_last, rd_resp_data};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
`else
    // Responses are ignored while idle; the RAM never produces one then.
    assign out_val     = w_busy & rd_resp_val;
    assign out_data    = rd_resp_data;
    assign rd_resp_rdy = w_busy & out_rdy;
    assign out_last    = out_val & w_recv_last;
    assign w_recv_inc  = w_out_hs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_cur_addr   <= '0;
            r_num_els    <= '0;
            r_issued_cnt <= '0;
            r_recv_cnt   <= '0;
        end else begin
            // w_recv_inc is gated by w_busy, so this never races the clear
            // performed on command acceptance below.
            if (w_recv_inc) begin
                r_recv_cnt <= r_recv_cnt + LEN_W_P'(1);
            end
            case (r_state)
                c_st_idle: begin
                    if (w_cmd_hs) begin
                        r_cur_addr   <= cmd_base_addr;
                        r_num_els    <= cmd_num_els;
                        r_issued_cnt <= '0;
                        r_recv_cnt   <= '0;
                        if (cmd_num_els != '0) begin
                            r_state <= c_st_issue;
                        end
                    end
                end
                c_st_issue: begin
                    if (w_req_hs) begin
                        r_issued_cnt <= w_issued_nxt;
                        r_cur_addr   <= (r_cur_addr == c_last_addr) ? '0
                                        : r_cur_addr + ADDR_W_P'(1);
                        if (w_issued_nxt == r_num_els) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    // The last-tagged beat is the final one held anywhere,
                    // so its handshake means every response has left.
                    if (w_out_hs && out_last) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_resp_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == c_st_idle) && rd_resp_val));
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_rd_streamer.sv
//==============================================================================
//  Module   : tb_ram_rd_streamer
//  Purpose  : Self-checking bench for ram_rd_streamer. Contains a model of the
//             synchronous backpressured RAM, a queue-based reference model of
//             the expected request addresses and output beats, and a per-cycle
//             compare process.
//  Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_rd_streamer;

    localparam int WIDTH = 256;
    localparam int ELS   = 64;
    localparam int AW    = 6;
    localparam int LW    = 16;
`ifdef RAM_RD_STREAMER_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam logic [WIDTH-1:0] NEW_DATA = {8{32'hBEEF_0003}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_val;
    logic [AW-1:0]    cmd_base_addr;
    logic [LW-1:0]    cmd_num_els;
    logic             cmd_rdy;
    logic             rd_req_val;
    logic [AW-1:0]    rd_req_addr;
    logic             rd_req_rdy;
    logic             rd_resp_val;
    logic [WIDTH-1:0] rd_resp_data;
    logic             rd_resp_rdy;
    logic             out_val;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_rdy;
    logic             busy;

    // RAM model signals
    logic             ram_gnt;
    logic             ram_resp_val;
    logic [WIDTH-1:0] ram_resp_data;
    logic [WIDTH-1:0] ram_mem [ELS];
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Reference model
    logic [WIDTH-1:0] model_mem [ELS];
    int               exp_addr [$];
    logic [WIDTH-1:0] exp_data [$];
    bit               exp_last [$];

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int rdy_mode = 0;
    int pat_idx = 0;
    bit stall_prev = 0;
    logic [AW-1:0] stall_addr = '0;

    always #5 clk = ~clk;

    ram_rd_streamer #(
        .WIDTH_P(WIDTH), .ELS_P(ELS), .ADDR_W_P(AW), .LEN_W_P(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_val(cmd_val), .cmd_base_addr(cmd_base_addr),
        .cmd_num_els(cmd_num_els), .cmd_rdy(cmd_rdy),
        .rd_req_val(rd_req_val), .rd_req_addr(rd_req_addr),
        .rd_req_rdy(rd_req_rdy),
        .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data),
        .rd_resp_rdy(rd_resp_rdy),
        .out_val(out_val), .out_data(out_data), .out_last(out_last),
        .out_rdy(out_rdy), .busy(busy)
    );

    function automatic logic [WIDTH-1:0] pat(input int i);
        logic [WIDTH-1:0] p;
        for (int j = 0; j < 8; j++) begin
            p[j*32 +: 32] = 32'hC0DE_0000 | (32'(j) << 8) | 32'(i);
        end
        return p;
    endfunction

    // Synchronous RAM: one-cycle read, response held until consumed,
    // write-first on a same-address collision, random request stalls.
    assign rd_req_rdy   = ram_gnt & (~ram_resp_val | rd_resp_rdy);
    assign rd_resp_val  = ram_resp_val;
    assign rd_resp_data = ram_resp_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_resp_val  <= 1'b0;
            ram_resp_data <= '0;
            for (int i = 0; i < ELS; i++) ram_mem[i] <= pat(i);
        end else begin
            if (wr_en) ram_mem[wr_addr] <= wr_data;
            if (rd_req_val && rd_req_rdy) begin
                ram_resp_val  <= 1'b1;
                ram_resp_data <= (wr_en && wr_addr == rd_req_addr) ? wr_data
                                 : ram_mem[rd_req_addr];
            end else if (rd_resp_rdy) begin
                ram_resp_val <= 1'b0;
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_model(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            int a;
            a = (base + k) % ELS;
            exp_addr.push_back(a);
            exp_data.push_back(model_mem[a]);
            exp_last.push_back(k == n - 1);
        end
    endtask

    // Per-cycle compare against the reference queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            chk1("busy_vs_cmd_rdy", busy, ~cmd_rdy);
            if (stall_prev) begin
                chk1("stall_hold_val", rd_req_val, 1'b1);
                chk32("stall_hold_addr", 32'(rd_req_addr), 32'(stall_addr));
            end
            if (rd_req_val && rd_req_rdy) begin
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_extra: got addr %0d want no request", rd_req_addr);
                end else begin
                    chk32("req_addr", 32'(rd_req_addr), 32'(exp_addr.pop_front()));
                end
            end
            if (out_val && out_rdy) begin
                beat_cnt++;
                if (exp_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_extra: got beat %h want none", out_data);
                end else begin
                    chkv("beat_data", out_data, exp_data.pop_front());
                    chk1("beat_last", out_last, exp_last.pop_front());
                end
            end
            if (!out_val) chk1("last_without_val", out_last, 1'b0);
            stall_prev = rd_req_val && !rd_req_rdy;
            stall_addr = rd_req_addr;
        end
    end

    // Downstream ready / RAM grant driver.
    initial begin
        out_rdy = 1'b1;
        ram_gnt = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: begin
                    out_rdy = ($urandom_range(0, 3) != 0);
                    ram_gnt = ($urandom_range(0, 4) != 0);
                end
                2: begin
                    out_rdy = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
                    ram_gnt = 1'b1;
                    pat_idx++;
                end
                default: begin
                    out_rdy = 1'b1;
                    ram_gnt = 1'b1;
                end
            endcase
        end
    end

    task automatic send_cmd(input int base, input int n);
        int guard;
        guard = 0;
        while (!cmd_rdy && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_rdy) begin
            checks++; errors++;
            $display("FAIL cmd_rdy_timeout: got cmd_rdy 0 want 1");
        end
        cmd_val       = 1'b1;
        cmd_base_addr = AW'(base);
        cmd_num_els   = LW'(n);
        push_model(base, n);
        @(posedge clk); #1;
        cmd_val = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while ((!cmd_rdy || exp_data.size() != 0 || exp_addr.size() != 0) && guard < 20000) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (guard >= 20000) begin
            errors++;
            $display("FAIL done_timeout: got %0d beats pending want 0", exp_data.size());
        end
    endtask

    // Cycle-exact check with out_rdy and grant held high. Cycle 0 is the
    // command handshake cycle.
    task automatic run_directed(input int base, input int n, input bit collide,
                                input logic [31:0] first_word);
        chk1("dir_idle", cmd_rdy, 1'b1);
        cmd_val       = 1'b1;
        cmd_base_addr = AW'(base);
        cmd_num_els   = LW'(n);
        if (collide) model_mem[3] = NEW_DATA;
        push_model(base, n);
        @(posedge clk); #1;
        cmd_val = 1'b0;
        if (collide) begin
            wr_en   = 1'b1;
            wr_addr = AW'(3);
            wr_data = NEW_DATA;
        end
        for (int k = 1; k <= n + LAT; k++) begin
            @(negedge clk);
            chk1("dir_req_val", rd_req_val, k <= n);
            if (k <= n) chk32("dir_req_addr", 32'(rd_req_addr), 32'((base + k - 1) % ELS));
            chk1("dir_out_val", out_val, (k >= LAT) && (k < LAT + n));
            chk1("dir_out_last", out_last, k == LAT + n - 1);
            chk1("dir_cmd_rdy", cmd_rdy, k >= LAT + n);
            if (k == LAT) chk32("dir_first_word", out_data[31:0], first_word);
            @(posedge clk); #1;
            wr_en = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int total;
        rst_n = 1'b0;
        cmd_val = 1'b0;
        cmd_base_addr = '0;
        cmd_num_els = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < ELS; i++) model_mem[i] = pat(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_cmd_rdy", cmd_rdy, 1'b1);
        chk1("rst_req_val", rd_req_val, 1'b0);
        chk1("rst_out_val", out_val, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic and wrap, cycle exact
        run_directed(5, 4, 1'b0, 32'hC0DE_0005);
        run_directed(62, 4, 1'b0, 32'hC0DE_003E);

        // Backpressure pattern 1,0,0,1
        rdy_mode = 2;
        pat_idx = 0;
        b0 = beat_cnt;
        send_cmd(0, 8);
        wait_done();
        chk32("bp_beat_count", 32'(beat_cnt - b0), 32'd8);

        // Zero-length command, then a real one the very next cycle
        rdy_mode = 0;
        @(posedge clk); #1;
        send_cmd(7, 0);
        chk1("zero_busy", busy, 1'b0);
        chk1("zero_cmd_rdy", cmd_rdy, 1'b1);
        chk1("zero_req_val", rd_req_val, 1'b0);
        @(negedge clk);
        chk1("zero_out_val", out_val, 1'b0);
        @(posedge clk); #1;
        send_cmd(9, 3);
        wait_done();

        // Reset mid-ISSUE
        rdy_mode = 1;
        send_cmd(20, 10);
        repeat (3) @(posedge clk);
        #1;
        chk1("pre_rst_req_val", rd_req_val, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_cmd_rdy", cmd_rdy, 1'b1);
        chk1("mid_rst_req_val", rd_req_val, 1'b0);
        chk1("mid_rst_out_val", out_val, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        exp_addr.delete();
        exp_data.delete();
        exp_last.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_directed(10, 5, 1'b0, 32'hC0DE_000A);

        // Randomized commands, including lengths beyond the RAM depth
        rdy_mode = 1;
        b0 = beat_cnt;
        total = 0;
        for (int it = 0; it < 30; it++) begin
            int base;
            int n;
            base = $urandom_range(0, ELS - 1);
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(65, 140) : $urandom_range(0, 20);
            send_cmd(base, n);
            total += n;
        end
        wait_done();
        chk32("rand_beat_count", 32'(beat_cnt - b0), 32'(total));

        // Write/read collision on addr 3
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        run_directed(3, 2, 1'b1, 32'hBEEF_0003);
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
